// File: rtl/fetch_invalidate_controller_pkg.sv
// Shared cache geometry constants for the fetch-side invalidate logic.
package CacheTypes;

    localparam int ICACHE_INDEX_WIDTH_DEFAULT = 6;
    localparam int TLB_INDEX_WIDTH_DEFAULT    = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/invalidate_walk_counter.sv
// Walk index counter shared by the ICache and ITLB invalidate walks.
// Clear wins over increment; the count saturates at max_i (no wrap).
module invalidate_walk_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [WIDTH-1:0] max_i,
    output logic [WIDTH-1:0] count_o,
    output logic             last_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign last_o  = (count_q == max_i);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !last_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fetch_invalidate_controller.sv
// Sequences ICache / ITLB invalidate walks requested by execute, stalling fetch
// until both walks finish; outputs are decoded from registered state only.
module fetch_invalidate_controller
    import CacheTypes::*;
#(
    parameter int ICACHE_INDEX_WIDTH = ICACHE_INDEX_WIDTH_DEFAULT,
    parameter int TLB_INDEX_WIDTH    = TLB_INDEX_WIDTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          invalidateICache,
    input  logic                          invalidateTlb,
    input  logic                          memBusy,
    output logic                          busy,
    output logic                          done,
    output logic                          fetchFlush,
    output logic                          iCacheInvalidateValid,
    output logic [ICACHE_INDEX_WIDTH-1:0] iCacheInvalidateIndex,
    output logic                          tlbInvalidateValid,
    output logic [TLB_INDEX_WIDTH-1:0]    tlbInvalidateIndex
);

    localparam int CNT_W = max_int(ICACHE_INDEX_WIDTH, TLB_INDEX_WIDTH);
    localparam logic [CNT_W-1:0] IC_LAST  = CNT_W'((1 << ICACHE_INDEX_WIDTH) - 1);
    localparam logic [CNT_W-1:0] TLB_LAST = CNT_W'((1 << TLB_INDEX_WIDTH) - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_DRAIN      = 3'd1;
    localparam logic [2:0] S_INV_ICACHE = 3'd2;
    localparam logic [2:0] S_INV_TLB    = 3'd3;
    localparam logic [2:0] S_DONE       = 3'd4;

    logic [2:0]       state_q, state_d;
    logic             pend_ic_q, pend_ic_d;
    logic             pend_tlb_q, pend_tlb_d;
    logic             start_ic, start_tlb;
    logic             walking;
    logic             walk_last;
    logic [CNT_W-1:0] walk_max;
    logic [CNT_W-1:0] walk_count;

    assign walking  = (state_q == S_INV_ICACHE) || (state_q == S_INV_TLB);
    assign walk_max = (state_q == S_INV_TLB) ? TLB_LAST : IC_LAST;

    invalidate_walk_counter #(
        .WIDTH (CNT_W)
    ) u_walk_counter (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (start_ic | start_tlb),
        .inc_i   (walking),
        .max_i   (walk_max),
        .count_o (walk_count),
        .last_o  (walk_last)
    );

    always_comb begin
        state_d   = state_q;
        start_ic  = 1'b0;
        start_tlb = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (invalidateICache || invalidateTlb || pend_ic_q || pend_tlb_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!memBusy) begin
                    if (pend_ic_q) begin
                        start_ic = 1'b1;
                    end else begin
                        start_tlb = 1'b1;
                    end
                end
            end
            S_INV_ICACHE, S_INV_TLB: begin
                // ICache re-walks go back through DRAIN so a new miss can settle first.
                if (walk_last) begin
                    if (pend_ic_q) begin
                        state_d = S_DRAIN;
                    end else if (pend_tlb_q) begin
                        start_tlb = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (invalidateICache || invalidateTlb || pend_ic_q || pend_tlb_q) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (start_ic) begin
            state_d = S_INV_ICACHE;
        end else if (start_tlb) begin
            state_d = S_INV_TLB;
        end
    end

    // A request in the same cycle a walk starts keeps its flag set.
    assign pend_ic_d  = (pend_ic_q  & ~start_ic)  | invalidateICache;
    assign pend_tlb_d = (pend_tlb_q & ~start_tlb) | invalidateTlb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pend_ic_q  <= 1'b0;
            pend_tlb_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_ic_q  <= pend_ic_d;
            pend_tlb_q <= pend_tlb_d;
        end
    end

    assign busy                  = (state_q != S_IDLE);
    assign done                  = (state_q == S_DONE);
    assign fetchFlush            = (state_q == S_DONE);
    assign iCacheInvalidateValid = (state_q == S_INV_ICACHE);
    assign tlbInvalidateValid    = (state_q == S_INV_TLB);
    assign iCacheInvalidateIndex = iCacheInvalidateValid ? walk_count[ICACHE_INDEX_WIDTH-1:0] : '0;
    assign tlbInvalidateIndex    = tlbInvalidateValid ? walk_count[TLB_INDEX_WIDTH-1:0] : '0;

endmodule
